lightswitch_bank: RTL

LIGHTSWITCH_BANK -- requirements
Module: lightswitch_bank

---
 rtl/lightswitch_bank.sv | 106 ++++++++++
 1 files changed

// File: rtl/lightswitch_bank.sv
// lightswitch_bank: per-channel synchronised, debounced buttons driving LEDs in momentary or toggle mode.
// Optional feature: define LIGHTSWITCH_BANK_EDGE_EN to add the EDGE accept-pulse output.
module lightswitch_bank #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] PIN,
    input  logic [CHANNELS-1:0] MODE,
    output logic [CHANNELS-1:0] LED,
`ifdef LIGHTSWITCH_BANK_EDGE_EN
    output logic [CHANNELS-1:0] EDGE,
`endif
    output logic                USBPU
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync1_r;
    logic [CHANNELS-1:0] sync2_r;
    logic [CHANNELS-1:0] stable_r;
    logic [CHANNELS-1:0] led_r;
    logic [CW-1:0]       cnt_r      [CHANNELS];
    logic [CW-1:0]       cnt_next_s [CHANNELS];
    logic [CHANNELS-1:0] stable_next_s;
    logic [CHANNELS-1:0] led_next_s;
    logic [CHANNELS-1:0] accept_s;
    logic [CHANNELS-1:0] rise_s;

    // Two-flop synchroniser for the raw asynchronous button pins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= PIN;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counters, accept detection and the LED mode logic for every channel.
    always_comb begin
        stable_next_s = stable_r;
        accept_s      = '0;
        led_next_s    = led_r;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_next_s[i] = cnt_r[i];
            if (sync2_r[i] == stable_r[i]) begin
                cnt_next_s[i] = '0;
            end else if (cnt_r[i] == CNT_MAX) begin
                cnt_next_s[i]    = '0;
                stable_next_s[i] = sync2_r[i];
                accept_s[i]      = 1'b1;
            end else begin
                cnt_next_s[i] = cnt_r[i] + CW'(1);
            end
        end
        rise_s = accept_s & stable_next_s;
        // Toggle mode only reacts to presses; momentary mode simply mirrors the debounced state.
        for (int i = 0; i < CHANNELS; i++) begin
            if (MODE[i]) begin
                led_next_s[i] = led_r[i] ^ rise_s[i];
            end else begin
                led_next_s[i] = stable_next_s[i];
            end
        end
    end

    // Debounced state, counters and LED drive registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stable_r <= '0;
            led_r    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            stable_r <= stable_next_s;
            led_r    <= led_next_s;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

`ifdef LIGHTSWITCH_BANK_EDGE_EN
    logic [CHANNELS-1:0] edge_r;

    // One-cycle pulse in the cycle following each accept, either direction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_r <= '0;
        end else begin
            edge_r <= accept_s;
        end
    end

    assign EDGE = edge_r;
`endif

    assign LED   = led_r;
    assign USBPU = 1'b0;

endmodule
